// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: default sample width, pooling window
// index and pooling FSM state encodings, and the signed compare helper used
// by the max-pool datapath.
package cnn_pkg;

  localparam int DATA_W_DEFAULT = 16;

  // Compare width for the helper. Callers sign-extend their samples to this
  // width, so a single function serves any DATA_W up to CMP_W.
  localparam int CMP_W = 64;

  typedef enum logic [1:0] {
    IDX_TL = 2'd0,
    IDX_TR = 2'd1,
    IDX_BL = 2'd2,
    IDX_BR = 2'd3
  } pool_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pool_state_t;

  // Signed max select: returns 1 when b strictly exceeds a, i.e. b becomes
  // the maximum and its position becomes the argmax. Ties keep a, the
  // earlier sample in raster order.
  function automatic logic signed_max_sel(input logic signed [CMP_W-1:0] a,
                                          input logic signed [CMP_W-1:0] b);
    return (b > a);
  endfunction

endpackage

// File: rtl/maxpool2d_stream_line_buffer.sv
// Line buffer for the max-pool stage: one entry per pooled column holding the
// top-pair maximum and the column bit of its winner. Synchronous write,
// asynchronous read. Contents are not reset; every entry is written on the
// even row before it is read on the following odd row.
module pool_line_buffer #(
  parameter int DEPTH = 31,
  parameter int WIDTH = 17,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Store the top-pair result for this column pair.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/maxpool2d_stream.sv
// Streaming 2x2 stride-2 max-pool with argmax index.
// Optional feature macro: POOL_RELU_EN (negative samples clamp to 0 before
// the compare, so outputs are never negative).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; in_ready low
// ST_RUN   | accepting the frame pixel by pixel in raster order
// ST_DRAIN | last pixel accepted; waiting for the final result to leave
module maxpool2d_stream
  import cnn_pkg::*;
#(
  parameter int FMAP_HEIGHT = 62,
  parameter int FMAP_WIDTH  = 62,
  parameter int DATA_W      = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_idx,
  output logic              busy,
  output logic              done
);

  localparam int PW = FMAP_WIDTH / 2;
  localparam int PH = FMAP_HEIGHT / 2;
  localparam int CW = $clog2(FMAP_WIDTH);
  localparam int RW = $clog2(FMAP_HEIGHT);
  localparam int AW = (PW > 1) ? $clog2(PW) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(FMAP_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(FMAP_HEIGHT - 1);
  localparam logic [CW:0]   COL_LIMIT = (CW + 1)'(2 * PW);
  localparam logic [RW:0]   ROW_LIMIT = (RW + 1)'(2 * PH);

  pool_state_t       r_state;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [DATA_W-1:0] r_hold;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  pool_idx_t         r_out_idx;
  logic              r_done;

  logic              w_acc;
  logic              w_keep;
  logic              w_last_pix;
  logic [DATA_W-1:0] w_samp;
  logic              w_pair_sel;
  logic [DATA_W-1:0] w_pair_max;
  logic              w_win_sel;
  logic [DATA_W-1:0] w_win_data;
  pool_idx_t         w_win_idx;
  logic              w_lb_we;
  logic [AW-1:0]     w_lb_addr;
  logic [DATA_W:0]   w_lb_wdata;
  logic [DATA_W:0]   w_lb_rdata;

  function automatic logic signed [CMP_W-1:0] sext(input logic [DATA_W-1:0] v);
    return {{(CMP_W - DATA_W){v[DATA_W-1]}}, v};
  endfunction

  assign in_ready   = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_acc      = in_valid && in_ready;
  assign w_keep     = ({1'b0, r_col} < COL_LIMIT) && ({1'b0, r_row} < ROW_LIMIT);
  assign w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);

  // Optional rectification of the incoming sample before it is held or compared.
  always_comb begin
    w_samp = in_data;
`ifdef POOL_RELU_EN
    if (in_data[DATA_W-1]) begin
      w_samp = '0;
    end
`else
    w_samp = in_data;
`endif
  end

  // Pair max (held even-column sample vs current odd-column sample), then the
  // window max of the bottom pair against the stored top pair.
  always_comb begin
    w_pair_sel = signed_max_sel(sext(r_hold), sext(w_samp));
    w_pair_max = w_pair_sel ? w_samp : r_hold;
    w_win_sel  = signed_max_sel(sext(w_lb_rdata[DATA_W-1:0]), sext(w_pair_max));
    w_win_data = w_win_sel ? w_pair_max : w_lb_rdata[DATA_W-1:0];
    if (w_win_sel) begin
      w_win_idx = w_pair_sel ? IDX_BR : IDX_BL;
    end else begin
      w_win_idx = w_lb_rdata[DATA_W] ? IDX_TR : IDX_TL;
    end
  end

  assign w_lb_we    = w_acc && w_keep && !r_row[0] && r_col[0];
  assign w_lb_addr  = AW'(r_col >> 1);
  assign w_lb_wdata = {w_pair_sel, w_pair_max};

  pool_line_buffer #(
    .DEPTH (PW),
    .WIDTH (DATA_W + 1),
    .AW    (AW)
  ) u_line_buffer (
    .clk       (clk),
    .i_wr_en   (w_lb_we),
    .i_wr_addr (w_lb_addr),
    .i_wr_data (w_lb_wdata),
    .i_rd_addr (w_lb_addr),
    .o_rd_data (w_lb_rdata)
  );

  // Frame sequencing and the registered done pulse. A start arriving while
  // done is still high is ignored so the two never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !r_done) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_acc && w_last_pix) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!r_out_valid || out_ready) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Raster counters, hold register and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row       <= '0;
      r_col       <= '0;
      r_hold      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= IDX_TL;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_state == ST_IDLE && start && !r_done) begin
        r_row  <= '0;
        r_col  <= '0;
        r_hold <= '0;
      end else if (w_acc) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
        if (w_keep && !r_col[0]) begin
          r_hold <= w_samp;
        end
        if (w_keep && r_row[0] && r_col[0]) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_win_data;
          r_out_idx   <= w_win_idx;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_maxpool2d_stream.sv
// Self-checking bench for maxpool2d_stream: a 4x4 instance and a 5x5
// instance share the input stimulus; sel picks which one is being exercised.
// Expected results come from a direct 2x2 window scan over the frame array.
module tb_maxpool2d_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sel;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_data;

  logic        a_in_ready, a_out_valid, a_busy, a_done;
  logic [15:0] a_out_data;
  logic [1:0]  a_out_idx;
  logic        b_in_ready, b_out_valid, b_busy, b_done;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_idx;

  logic        start_a, start_b;
  logic        m_in_ready, m_out_valid, m_busy, m_done;
  logic [15:0] m_out_data;
  logic [1:0]  m_out_idx;

  int n_chk = 0;
  int n_bad = 0;
  int pix [0:63];
  int exp_d [$];
  int exp_i [$];
  int got_d [0:15];
  int got_i [0:15];

  always #5 clk = ~clk;

  assign start_a     = start & ~sel;
  assign start_b     = start & sel;
  assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_out_data  = sel ? b_out_data  : a_out_data;
  assign m_out_idx   = sel ? b_out_idx   : a_out_idx;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_done      = sel ? b_done      : a_done;

  maxpool2d_stream #(.FMAP_HEIGHT(4), .FMAP_WIDTH(4), .DATA_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_idx(a_out_idx), .busy(a_busy), .done(a_done));

  maxpool2d_stream #(.FMAP_HEIGHT(5), .FMAP_WIDTH(5), .DATA_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_idx(b_out_idx), .busy(b_busy), .done(b_done));

  task automatic chk(input string tag, input integer got, input integer exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int relu_m(input int v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: scan each complete 2x2 window in raster order, keep the first
  // strictly larger value.
  task automatic build_expected(input int h, input int w);
    int best, bi, v;
    exp_d.delete();
    exp_i.delete();
    for (int pr = 0; pr < h / 2; pr++) begin
      for (int pc = 0; pc < w / 2; pc++) begin
        best = relu_m(pix[(2 * pr) * w + 2 * pc]);
        bi   = 0;
        for (int k = 1; k < 4; k++) begin
          v = relu_m(pix[(2 * pr + k / 2) * w + 2 * pc + k % 2]);
          if (v > best) begin
            best = v;
            bi   = k;
          end
        end
        exp_d.push_back(best);
        exp_i.push_back(bi);
      end
    end
  endtask

  // mode 0: full rate, 1: random valid/ready, 2: 10-cycle stall at the first
  // output, 3: full rate with a stray start mid-frame. abort_n > 0 stops
  // driving after that many accepts and returns without end-of-frame checks.
  task automatic run_frame(input int h, input int w, input int mode, input int abort_n);
    int n_acc, n_out, n_done, n_extra, cyc, since, stall_left, t;
    bit seen_done, prev_stall;
    logic [15:0] prev_d;
    logic [1:0]  prev_i;
    build_expected(h, w);
    n_acc = 0; n_out = 0; n_done = 0; n_extra = 0; cyc = 0; since = 0;
    stall_left = (mode == 2) ? 10 : 0;
    seen_done = 1'b0; prev_stall = 1'b0; prev_d = '0; prev_i = '0;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", m_busy, 1);
    while (!seen_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      since++;
      if (prev_stall) begin
        chk("stall_data_stable", m_out_data, prev_d);
        chk("stall_idx_stable", m_out_idx, prev_i);
      end
      if (m_done) begin
        n_done++;
        seen_done = 1'b1;
        if (mode == 0) chk("done_latency", since, 2);
      end
      if (n_acc < h * w) in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      else in_valid = 1'b0;
      in_data = pix[n_acc][15:0];
      if (mode == 1) out_ready = ($urandom_range(0, 2) != 0);
      else if (stall_left > 0 && m_out_valid) begin
        out_ready = 1'b0;
        stall_left--;
      end else out_ready = 1'b1;
      start = (mode == 3 && n_acc == 5) ? 1'b1 : 1'b0;
      #1;
      if (m_out_valid && !out_ready) chk("backpressure_in_ready", m_in_ready, 0);
      prev_stall = m_out_valid && !out_ready;
      prev_d = m_out_data;
      prev_i = m_out_idx;
      if (m_out_valid && out_ready) begin
        t = $signed(m_out_data);
        if (exp_d.size() == 0) chk("output_overflow", n_out + 1, (h / 2) * (w / 2));
        else begin
          chk("out_data", t, exp_d.pop_front());
          chk("out_idx", m_out_idx, exp_i.pop_front());
        end
        if (n_out < 16) begin
          got_d[n_out] = t;
          got_i[n_out] = m_out_idx;
        end
        n_out++;
      end
      if (in_valid && m_in_ready) begin
        n_acc++;
        since = 0;
      end
      if (abort_n > 0 && n_acc >= abort_n) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", seen_done, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (m_done) n_done++;
      if (m_out_valid) n_extra++;
    end
    chk("no_trailing_output", n_extra, 0);
    chk("output_count", n_out, (h / 2) * (w / 2));
    chk("accept_count", n_acc, h * w);
    chk("done_count", n_done, 1);
    chk("busy_idle", m_busy, 0);
  endtask

  task automatic check_reset_a_b();
    chk("rst_in_ready_a", a_in_ready, 0);
    chk("rst_out_valid_a", a_out_valid, 0);
    chk("rst_out_data_a", a_out_data, 0);
    chk("rst_out_idx_a", a_out_idx, 0);
    chk("rst_busy_a", a_busy, 0);
    chk("rst_done_a", a_done, 0);
    chk("rst_in_ready_b", b_in_ready, 0);
    chk("rst_out_valid_b", b_out_valid, 0);
    chk("rst_busy_b", b_busy, 0);
    chk("rst_done_b", b_done, 0);
  endtask

  initial begin
    logic [15:0] rv;
    int v;
    rst = 1'b1; start = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_a_b();
    @(negedge clk);
    rst = 1'b0;

    // 4x4 ramp 1..16
    sel = 1'b0;
    for (int k = 0; k < 16; k++) pix[k] = k + 1;
    run_frame(4, 4, 0, 0);
    chk("ramp_out0", got_d[0], 6);
    chk("ramp_out1", got_d[1], 8);
    chk("ramp_out2", got_d[2], 14);
    chk("ramp_out3", got_d[3], 16);
    for (int k = 0; k < 4; k++) chk("ramp_idx", got_i[k], 3);

    // 5x5 ramp: last row and column discarded
    sel = 1'b1;
    for (int k = 0; k < 25; k++) pix[k] = k + 1;
    run_frame(5, 5, 0, 0);
    chk("odd_out0", got_d[0], 7);
    chk("odd_out3", got_d[3], 19);

    // tie window and all-negative window
    sel = 1'b0;
    for (int k = 0; k < 16; k++) pix[k] = $urandom_range(0, 50);
    pix[0] = 7;  pix[1] = 7;  pix[4] = 7;  pix[5] = 7;
    pix[2] = -3; pix[3] = -9; pix[6] = -1; pix[7] = -5;
    run_frame(4, 4, 0, 0);
    chk("tie_data", got_d[0], 7);
    chk("tie_idx", got_i[0], 0);
`ifdef POOL_RELU_EN
    chk("neg_data", got_d[1], 0);
    chk("neg_idx", got_i[1], 0);
`else
    chk("neg_data", got_d[1], -1);
    chk("neg_idx", got_i[1], 2);
`endif

    // output stall of 10 cycles
    for (int k = 0; k < 16; k++) pix[k] = 16 - k;
    run_frame(4, 4, 2, 0);

    // aborted frame, reset, fresh frame
    for (int k = 0; k < 16; k++) pix[k] = 1000 + k;
    run_frame(4, 4, 0, 7);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset_a_b();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) pix[k] = k + 1;
    run_frame(4, 4, 0, 0);
    chk("after_rst_out0", got_d[0], 6);
    chk("after_rst_out3", got_d[3], 16);

    // stray start during RUN
    sel = 1'b1;
    for (int k = 0; k < 25; k++) pix[k] = $urandom_range(0, 200);
    run_frame(5, 5, 3, 0);

    // randomized frames: narrow range (many ties) then full signed range
    for (int f = 0; f < 8; f++) begin
      sel = f[0];
      for (int k = 0; k < 25; k++) begin
        if (f < 4) begin
          v = $urandom_range(0, 8);
          pix[k] = v - 4;
        end else begin
          rv = 16'($urandom);
          pix[k] = $signed(rv);
        end
      end
      if (sel) run_frame(5, 5, 1, 0);
      else run_frame(4, 4, 1, 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/maxpool2d_stream.md
# maxpool2d_stream

Streaming 2×2, stride-2 max-pool stage directly downstream of the 2-D convolution forward stage. It consumes the convolution feature map one pixel per handshake in raster order and emits pooled values in raster order. Each pooled value carries a 2-bit argmax index that the pooling backward stage uses to route gradients. Rows and columns that do not complete a 2×2 window (odd dimensions) are accepted and discarded.

## Interface
Parameters:
- FMAP_HEIGHT, 62: input feature-map rows; must be ≥ 2.
- FMAP_WIDTH, 62: input feature-map columns; must be ≥ 2.
- DATA_W, 16: feature-map sample width, two's-complement signed.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begins one frame; honoured only in IDLE.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  stage accepts a sample this cycle.
- in_data  in  DATA_W  feature-map sample, signed.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  pooled maximum, signed.
- out_idx  out  2  window position of the maximum: 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at frame completion.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN on start. On the same edge, clear the row/col counters and the hold register.
- RUN → DRAIN on the edge that accepts pixel (FMAP_HEIGHT-1, FMAP_WIDTH-1).
- DRAIN → IDLE when the output register is empty, or is being emptied (out_valid && out_ready). done pulses high on that edge.
- Acceptance: a sample is accepted when in_valid && in_ready. Then in_ready = (state==RUN) && (!out_valid || out_ready).
- Counters: col increments per accepted sample and wraps to 0 after FMAP_WIDTH-1, at which point row increments.
- Let PW = FMAP_WIDTH/2 and PH = FMAP_HEIGHT/2 (floor). A pixel is discarded when col ≥ 2·PW or row ≥ 2·PH.
- Even row:
  - Even col: store the sample in the hold register.
  - Odd col: write the pair maximum and its index bit into line-buffer entry col>>1.
- Odd row:
  - Even col: hold the sample.
  - Odd col: compute the bottom-pair maximum and compare it against line-buffer entry col>>1.
  - Load the output register with the window maximum and out_idx; set out_valid.
- Comparison is signed. Replacement uses strict greater-than, so ties keep the earliest raster position (lowest idx).
- out_valid stays high and out_data/out_idx stay stable until out_ready.
- start outside IDLE is ignored.
- rst at any time: state IDLE, the partial frame is abandoned, and the line buffer contents are don't-care.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, out_idx 0, busy 0, done 0.
- Latency: out_valid rises the cycle after the bottom-right window pixel is accepted.
- Throughput: one input per cycle with out_ready held high.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 the same cycle (combinational from out_ready and the registered out_valid).
- Output count per frame is exactly PH·PW.
- done is registered and is never asserted in the same cycle as start being honoured.
- A frame of H·W samples with no stalls completes with done two cycles after the last accept: one cycle for DRAIN while the last result is consumed, one for the registered pulse.

## Configuration
- POOL_RELU_EN defined: each sample with its sign bit set is replaced by 0 before hold/compare. out_data is then never negative. An all-negative window yields 0 with idx 0.
- POOL_RELU_EN undefined: raw signed maximum; negative outputs are legal.

## Structure
- Shared package cnn_pkg holds:
  - DATA_W default.
  - pool_idx_t (2-bit enum TL/TR/BL/BR).
  - pool_state_t (IDLE/RUN/DRAIN).
  - A signed-max-with-index helper function.
- Sub-module pool_line_buffer: PW entries of DATA_W+1 bits (value plus column bit of the top-pair winner). One synchronous write port, one asynchronous read port, addressed by col>>1.

## Test plan
- 4×4 frame with rows 1..4, 5..8, 9..12, 13..16, out_ready=1 → outputs 6,8,14,16 in order, all idx 3, done once.
- 5×5 frame (odd dims) → exactly 4 outputs; row 4 and col 4 accepted and discarded; done after the 25th accept.
- Window {7,7,7,7} → idx 0. Window {-3,-9,-1,-5}: without macro → out -1 idx 2; with POOL_RELU_EN → out 0 idx 0.
- Hold out_ready=0 for 10 cycles after the first output → in_ready low, out_data stable, no sample lost; totals unchanged.
- Assert rst mid-frame after 7 accepts, then start a fresh 4×4 frame → correct 4 outputs with no residue from the aborted frame.
- start pulsed during RUN → ignored; the frame completes with the normal output count and a single done.
